// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_resp_pkg
//  Brief   : Shared types and constants for the mem_resp memory responder:
//            FSM state encoding, byte-address alignment and address checking.
//  Revision: 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of low byte-address bits that must be zero for a word access
  localparam int ADDR_ALIGN_BITS = 2;

  // Width of the byte address presented by the initiator
  localparam int ADDR_W = 16;

  // A request is erroneous when it is not word aligned or its word index
  // lies beyond the end of storage.
  function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr,
                                       input int                depth);
    logic [31:0] word_idx;
    word_idx = 32'(addr >> ADDR_ALIGN_BITS);
    return (addr[ADDR_ALIGN_BITS-1:0] != '0) || (word_idx >= 32'(depth));
  endfunction

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/mem_resp_bram.sv
`default_nettype none
// ============================================================================
//  Module  : bram_be
//  Brief   : Single-port block RAM with per-byte write enables, synchronous
//            write and synchronous (registered) read. Contents have no reset.
//  Revision: 1.0 - initial release
// ============================================================================
module bram_be #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Byte-lane write: only lanes with their enable set are updated
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; output holds its value until the next read
  always_ff @(posedge clk) begin
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : bram_be
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
//  Module  : mem_resp
//  Brief   : Valid/ready memory responder. Accepts one load or store at a
//            time, inserts WAIT wait-state cycles, then presents a response
//            held until the initiator consumes it. Misaligned or out-of-range
//            requests are answered after one cycle with resp_err set and never
//            touch storage. DEPTH may be at most 16384 words.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [15:0]        req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_wstrb,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               resp_err
);

  localparam int NB      = WIDTH / 8;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_M1 = (WAIT > 0) ? WAIT - 1 : 0;
  localparam int CW      = (WAIT_M1 > 0) ? $clog2(WAIT_M1 + 1) : 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [NB-1:0]    wstrb_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             rdata_sel_q;   // response carries load data

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic             req_fire;
  logic             req_bad;
  logic [AW-1:0]    req_word;

  assign req_fire = req_valid && (state_q == ST_IDLE);
  assign req_bad  = addr_is_bad(req_addr, DEPTH);
  assign req_word = req_addr[ADDR_ALIGN_BITS +: AW];

  // --------------------------------------------------------------------------
  // Storage access. The access happens on the edge that enters RESP. With no
  // wait states that edge is the accept edge itself, so the command comes
  // straight from the request inputs; otherwise it comes from the latched copy.
  // Reset suppresses the access so an uncommitted store is dropped.
  // --------------------------------------------------------------------------
  logic             mem_en;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic [NB-1:0]    cmd_wstrb;
  logic [WIDTH-1:0] mem_rdata;

  // Select command source and decide whether storage is touched this edge
  always_comb begin
    cmd_we    = we_q;
    cmd_addr  = addr_q;
    cmd_wdata = wdata_q;
    cmd_wstrb = wstrb_q;
    mem_en    = 1'b0;
    if (state_q == ST_IDLE) begin
      cmd_we    = req_we;
      cmd_addr  = req_word;
      cmd_wdata = req_wdata;
      cmd_wstrb = req_wstrb;
    end
    if (rst) begin
      if (state_q == ST_IDLE) begin
        mem_en = req_fire && !req_bad && (WAIT == 0);
      end else if (state_q == ST_WAIT) begin
        mem_en = (cnt_q == '0);
      end
    end
  end

  bram_be #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bram (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (cmd_we),
    .be_i    (cmd_wstrb),
    .addr_i  (cmd_addr),
    .wdata_i (cmd_wdata),
    .rdata_o (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Control FSM with registered response flags
  // --------------------------------------------------------------------------
  // Sequence IDLE -> (WAIT) -> RESP -> IDLE and hold the response until taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_sel_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            we_q    <= req_we;
            addr_q  <= req_word;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_bad) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              rdata_sel_q  <= 1'b0;
            end else if (WAIT == 0) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              rdata_sel_q  <= !req_we;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CW'(WAIT_M1);
            end
          end
        end

        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            rdata_sel_q  <= !we_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_sel_q  <= 1'b0;
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rdata_sel_q  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Load data comes from the RAM output register, which was loaded
  // on the edge entering RESP and is not re-read until the next transaction.
  // --------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_sel_q ? mem_rdata : '0;

endmodule : mem_resp
`default_nettype wire
